// File: rtl/qdec_cabac_pkg.sv
// Shared types and constants for the CABAC context store.
// Stored context word layout: {pad, pStateIdx, valMps}.
package qdec_cabac_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    SAVE    = 2'd2,
    RESTORE = 2'd3
  } ctx_state_e;

  typedef struct packed {
    logic       pad;
    logic [5:0] p_state;
    logic       val_mps;
  } ctx_word_t;

  localparam int MAX_QP  = 51;
  localparam int PRE_MIN = 1;
  localparam int PRE_MAX = 126;

endpackage

// File: rtl/basic_ram.sv
// Simple dual-port RAM: one write port and one read port.
// The read data is registered, so it appears one cycle after the read.
module basic_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/qdec_ctx_init_calc.sv
// Combinational initValue + slice QP -> initial context word.
// Intermediate values are signed 13-bit; the >>> is a floor shift.
module qdec_ctx_init_calc
  import qdec_cabac_pkg::*;
(
  input  logic [7:0] init_value,
  input  logic [5:0] qp,
  output ctx_word_t  word
);

  logic        [5:0]  qp_clamped;
  logic signed [12:0] m;
  logic signed [12:0] n;
  logic signed [12:0] prod;
  logic signed [12:0] pre_raw;
  logic        [6:0]  pre;
  logic        [6:0]  p_state_wide;
  logic               val_mps;

  always_comb begin
    qp_clamped = (qp > 6'(MAX_QP)) ? 6'(MAX_QP) : qp;
    m          = $signed({9'd0, init_value[7:4]}) * 13'sd5 - 13'sd45;
    n          = $signed({6'd0, init_value[3:0], 3'd0}) - 13'sd16;
    prod       = m * $signed({7'd0, qp_clamped});
    pre_raw    = (prod >>> 4) + n;

    if (pre_raw < 13'(PRE_MIN)) begin
      pre = 7'(PRE_MIN);
    end else if (pre_raw > 13'(PRE_MAX)) begin
      pre = 7'(PRE_MAX);
    end else begin
      pre = pre_raw[6:0];
    end

    val_mps      = (pre > 7'd63);
    p_state_wide = val_mps ? (pre - 7'd64) : (7'd63 - pre);

    word         = '0;
    word.pad     = 1'b0;
    word.p_state = p_state_wide[5:0];
    word.val_mps = val_mps;
  end

endmodule

// File: rtl/qdec_ctx_store.sv
// CABAC context-variable store: main bank with a one-cycle read port,
// a hardware init sweep from the initValue ROM and a WPP sync bank.
module qdec_ctx_store
  import qdec_cabac_pkg::*;
#(
  parameter int NUM_CTX = 1024,
  parameter int ADDR_W  = $clog2(NUM_CTX),
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  input  logic [5:0]        slice_qp,
  output logic [ADDR_W-1:0] init_rom_addr,
  input  logic [7:0]        init_rom_data,
  input  logic              sync_save,
  input  logic              sync_restore,
  output logic              sync_valid,
  output logic              ctx_ready,
  input  logic              ctx_re,
  input  logic              ctx_we,
  input  logic [ADDR_W-1:0] ctx_addr,
  input  logic [DATA_W-1:0] ctx_wdata,
  output logic [DATA_W-1:0] ctx_rdata,
  output logic              ctx_rvalid,
  output logic              busy
);

  localparam int CNT_W = $clog2(NUM_CTX + 1);

  ctx_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [5:0]        qp_reg, qp_next;
  logic              sync_valid_reg, sync_valid_next;
  logic [ADDR_W-1:0] sweep_waddr_reg;

  logic              rvalid_reg;
  logic              bypass_reg;
  logic [DATA_W-1:0] bypass_data_reg;
  logic [DATA_W-1:0] hold_reg;

  logic              acc_re, acc_we;
  logic              sweep_wr;
  logic [ADDR_W-1:0] sweep_raddr;

  logic              main_we, main_re;
  logic [ADDR_W-1:0] main_waddr, main_raddr;
  logic [DATA_W-1:0] main_wdata, main_rdata;
  logic              sync_we, sync_re;
  logic [DATA_W-1:0] sync_rdata;

  ctx_word_t         init_word;
  logic [7:0]        init_bits;

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      qp_reg          <= '0;
      sync_valid_reg  <= 1'b0;
      sweep_waddr_reg <= '0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      qp_reg          <= qp_next;
      sync_valid_reg  <= sync_valid_next;
      sweep_waddr_reg <= cnt_reg[ADDR_W-1:0];
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    qp_next         = qp_reg;
    sync_valid_next = sync_valid_reg;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (init_start) begin
          state_next = INIT;
          qp_next    = slice_qp;
        end else if (sync_restore && sync_valid_reg) begin
          state_next = RESTORE;
        end else if (sync_save) begin
          state_next = SAVE;
        end
      end
      default: begin
        // Count 0..NUM_CTX: reads at 0..NUM_CTX-1, writes trail by one.
        if (cnt_reg == CNT_W'(NUM_CTX)) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (state_reg == SAVE) begin
            sync_valid_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    endcase
  end

  assign ctx_ready     = (state_reg == IDLE);
  assign busy          = !ctx_ready;
  assign sync_valid    = sync_valid_reg;
  assign init_rom_addr = cnt_reg[ADDR_W-1:0];

  assign sweep_wr    = (state_reg != IDLE) && (cnt_reg != '0);
  assign sweep_raddr = cnt_reg[ADDR_W-1:0];
  assign acc_re      = ctx_ready && ctx_re;
  assign acc_we      = ctx_ready && ctx_we;

  // ---------------------------------------------------------------
  // Init arithmetic on the ROM word returned this cycle
  // ---------------------------------------------------------------
  qdec_ctx_init_calc u_init_calc (
    .init_value (init_rom_data),
    .qp         (qp_reg),
    .word       (init_word)
  );

  assign init_bits = init_word;

  // ---------------------------------------------------------------
  // Bank port muxing
  // ---------------------------------------------------------------
  always_comb begin
    main_we    = acc_we;
    main_waddr = ctx_addr;
    main_wdata = ctx_wdata;
    main_re    = acc_re;
    main_raddr = ctx_addr;
    sync_we    = 1'b0;
    sync_re    = 1'b0;

    case (state_reg)
      INIT: begin
        main_we    = sweep_wr;
        main_waddr = sweep_waddr_reg;
        main_wdata = DATA_W'(init_bits);
      end
      RESTORE: begin
        sync_re    = 1'b1;
        main_we    = sweep_wr;
        main_waddr = sweep_waddr_reg;
        main_wdata = sync_rdata;
      end
      SAVE: begin
        main_we    = 1'b0;
        main_re    = 1'b1;
        main_raddr = sweep_raddr;
        sync_we    = sweep_wr;
      end
      default: ;
    endcase
  end

  basic_ram #(
    .DEPTH  (NUM_CTX),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_main_bank (
    .clk   (clk),
    .we    (main_we),
    .waddr (main_waddr),
    .wdata (main_wdata),
    .re    (main_re),
    .raddr (main_raddr),
    .rdata (main_rdata)
  );

  basic_ram #(
    .DEPTH  (NUM_CTX),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_sync_bank (
    .clk   (clk),
    .we    (sync_we),
    .waddr (sweep_waddr_reg),
    .wdata (main_rdata),
    .re    (sync_re),
    .raddr (sweep_raddr),
    .rdata (sync_rdata)
  );

  // ---------------------------------------------------------------
  // Read return path: write-first bypass and hold between reads
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_reg      <= 1'b0;
      bypass_reg      <= 1'b0;
      bypass_data_reg <= '0;
      hold_reg        <= '0;
    end else begin
      rvalid_reg <= acc_re;
      if (acc_re) begin
        bypass_reg      <= acc_we && (ctx_addr == ctx_addr);
        bypass_data_reg <= ctx_wdata;
      end
      if (rvalid_reg) begin
        hold_reg <= ctx_rdata;
      end
    end
  end

  // The RAM output register moves during SAVE sweeps, so a held copy
  // is shown whenever no fresh read result is due.
  assign ctx_rdata  = rvalid_reg ? (bypass_reg ? bypass_data_reg : main_rdata) : hold_reg;
  assign ctx_rvalid = rvalid_reg;

endmodule

// File: tb/tb_qdec_ctx_store.sv
// Directed self-checking bench for qdec_ctx_store with a behavioural ROM.
module tb_qdec_ctx_store;

  localparam int NUM_CTX = 1024;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              init_start;
  logic [5:0]        slice_qp;
  logic [ADDR_W-1:0] init_rom_addr;
  logic [7:0]        init_rom_data;
  logic              sync_save;
  logic              sync_restore;
  logic              sync_valid;
  logic              ctx_ready;
  logic              ctx_re;
  logic              ctx_we;
  logic [ADDR_W-1:0] ctx_addr;
  logic [DATA_W-1:0] ctx_wdata;
  logic [DATA_W-1:0] ctx_rdata;
  logic              ctx_rvalid;
  logic              busy;

  logic [7:0] rom [NUM_CTX];

  int n_checks = 0;
  int n_fail   = 0;

  qdec_ctx_store #(
    .NUM_CTX (NUM_CTX),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .init_start    (init_start),
    .slice_qp      (slice_qp),
    .init_rom_addr (init_rom_addr),
    .init_rom_data (init_rom_data),
    .sync_save     (sync_save),
    .sync_restore  (sync_restore),
    .sync_valid    (sync_valid),
    .ctx_ready     (ctx_ready),
    .ctx_re        (ctx_re),
    .ctx_we        (ctx_we),
    .ctx_addr      (ctx_addr),
    .ctx_wdata     (ctx_wdata),
    .ctx_rdata     (ctx_rdata),
    .ctx_rvalid    (ctx_rvalid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM with one cycle of latency
  always @(posedge clk) init_rom_data <= rom[init_rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic i_init, input logic i_save, input logic i_restore,
                     input logic [5:0] qp);
    init_start   = i_init;
    sync_save    = i_save;
    sync_restore = i_restore;
    slice_qp     = qp;
    tick();
    init_start   = 1'b0;
    sync_save    = 1'b0;
    sync_restore = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int c = 0;
    while (busy && c < 4000) begin
      tick();
      c++;
    end
    check(tag, c, exp_cycles);
  endtask

  task automatic write_ctx(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ctx_we    = 1'b1;
    ctx_addr  = a;
    ctx_wdata = d;
    tick();
    ctx_we    = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] exp);
    ctx_re   = 1'b1;
    ctx_addr = a;
    tick();
    ctx_re   = 1'b0;
    check({tag, "_rvalid"}, ctx_rvalid, 1);
    check(tag, ctx_rdata, exp);
  endtask

  initial begin
    for (int i = 0; i < NUM_CTX; i++) rom[i] = 8'((i * 7) & 8'hFF);
    rom[0] = 8'd154;
    rom[1] = 8'd139;
    rom[2] = 8'd0;
    rom[3] = 8'd154;
    rom[4] = 8'hF0;

    rst_n = 1'b0; init_start = 1'b0; slice_qp = '0; sync_save = 1'b0;
    sync_restore = 1'b0; ctx_re = 1'b0; ctx_we = 1'b0; ctx_addr = '0; ctx_wdata = '0;
    #1;
    check("rst_ready", ctx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rvalid", ctx_rvalid, 0);
    check("rst_sync_valid", sync_valid, 0);
    check("rst_rdata", ctx_rdata, 0);
    check("rst_rom_addr", init_rom_addr, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // restore with no snapshot is ignored
    cmd(1'b0, 1'b0, 1'b1, 6'd0);
    check("restore_nosave_busy", busy, 0);
    wait_idle("restore_nosave_len", 0);

    // init qp=26
    cmd(1'b1, 1'b0, 1'b0, 6'd26);
    check("init26_busy", busy, 1);
    wait_idle("init26_len", NUM_CTX + 1);
    check("init26_ready", ctx_ready, 1);
    read_chk("q26_a0", 10'd0, 8'h01);
    read_chk("q26_a4", 10'd4, 8'h3E);
    read_chk("q26_a1023", 10'd1023, 8'h51);

    // init + save together: init wins, reads during sweep dropped
    cmd(1'b1, 1'b1, 1'b0, 6'd30);
    ctx_re = 1'b1; ctx_addr = 10'd0;
    tick();
    ctx_re = 1'b0;
    check("sweep_re_dropped", ctx_rvalid, 0);
    wait_idle("init30_len", NUM_CTX);
    check("init_save_sync_valid", sync_valid, 0);
    read_chk("q30_a1", 10'd1, 8'h02);
    read_chk("q30_a4", 10'd4, 8'h2E);

    // qp 60 clamps to 51
    cmd(1'b1, 1'b0, 1'b0, 6'd60);
    wait_idle("init60_len", NUM_CTX + 1);
    read_chk("q60_a1", 10'd1, 8'h0E);
    read_chk("q60_a2", 10'd2, 8'h7C);
    read_chk("q60_a3", 10'd3, 8'h01);
    read_chk("q60_a4", 10'd4, 8'h1F);

    // access port and write-first bypass
    write_ctx(10'd5, 8'h3B);
    read_chk("wr_a5", 10'd5, 8'h3B);
    ctx_re = 1'b1; ctx_we = 1'b1; ctx_addr = 10'd5; ctx_wdata = 8'h11;
    tick();
    ctx_re = 1'b0; ctx_we = 1'b0;
    check("bypass_rvalid", ctx_rvalid, 1);
    check("bypass_rdata", ctx_rdata, 8'h11);
    tick();
    check("hold_rvalid", ctx_rvalid, 0);
    check("hold_rdata", ctx_rdata, 8'h11);
    read_chk("bypass_written", 10'd5, 8'h11);

    // save / overwrite / restore
    write_ctx(10'd7, 8'h22);
    cmd(1'b0, 1'b1, 1'b0, 6'd0);
    wait_idle("save_len", NUM_CTX + 1);
    check("save_sync_valid", sync_valid, 1);
    write_ctx(10'd7, 8'h55);
    read_chk("ovr_a7", 10'd7, 8'h55);
    cmd(1'b0, 1'b0, 1'b1, 6'd0);
    check("restore_busy", busy, 1);
    wait_idle("restore_len", NUM_CTX + 1);
    read_chk("rest_a7", 10'd7, 8'h22);
    read_chk("rest_a5", 10'd5, 8'h11);
    read_chk("rest_a4", 10'd4, 8'h1F);
    check("restore_sync_valid", sync_valid, 1);

    // reset at i=100 of an init sweep
    cmd(1'b1, 1'b0, 1'b0, 6'd30);
    repeat (100) tick();
    check("mid_rom_addr", init_rom_addr, 100);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ready", ctx_ready, 1);
    check("midrst_sync_valid", sync_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    cmd(1'b1, 1'b0, 1'b0, 6'd26);
    wait_idle("reinit_len", NUM_CTX + 1);
    read_chk("re26_a0", 10'd0, 8'h01);
    read_chk("re26_a2", 10'd2, 8'h7C);
    read_chk("re26_a4", 10'd4, 8'h3E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
